// File: rtl/quickq_pkg.sv
// Shared types and helpers for the QuickQ node insertion engine.
// Address helper maps (node, slot) onto the flat block-RAM index space.
package quickq_pkg;

    localparam int KEY_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_COMPARE,
        ST_SWAP,
        ST_APPEND,
        ST_SPILL
    } state_t;

    function automatic int unsigned slot_addr(input int unsigned node,
                                              input int unsigned slot,
                                              input int unsigned slots);
        return node * slots + slot;
    endfunction

endpackage

// File: rtl/quickq_node_count.sv
// Per-node occupancy counters: combinational read by node, single increment
// strobe, cleared asynchronously with the engine.
module quickq_node_count #(
    parameter  int NODES  = 16,
    parameter  int SLOTS  = 4,
    localparam int NODE_W = $clog2(NODES),
    localparam int CNT_W  = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] rd_node,
    output logic [CNT_W-1:0]  rd_cnt,
    input  logic              inc,
    input  logic [NODE_W-1:0] inc_node
);

    logic [NODES-1:0][CNT_W-1:0] cnt_q;
    logic [NODES-1:0][CNT_W-1:0] cnt_d;

    for (genvar gi = 0; gi < NODES; gi++) begin : g_cnt
        assign cnt_d[gi] = (inc && inc_node == NODE_W'(gi)) ? cnt_q[gi] + CNT_W'(1)
                                                              : cnt_q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt = cnt_q[rd_node];

endmodule

// File: rtl/quickq_node_insert.sv
// Inserts one key into a sorted QuickQ node held in external block RAM,
// appending when the node has room and spilling the largest key otherwise.
module quickq_node_insert
    import quickq_pkg::*;
#(
    parameter  int KEY_W  = KEY_W_DEF,
    parameter  int SLOTS  = 4,
    parameter  int NODES  = 16,
    localparam int NODE_W = $clog2(NODES),
    localparam int ADDR_W = $clog2(NODES * SLOTS),
    localparam int CNT_W  = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [NODE_W-1:0] in_node,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [KEY_W-1:0]  out_key,
    output logic [NODE_W-1:0] out_node,
    output logic              out_overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [KEY_W-1:0]  mem_wdata,
    input  logic [KEY_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              result,
    output logic              done
);

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  temp_q, temp_d;
    logic [KEY_W-1:0]  hold_q, hold_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    logic [NODE_W-1:0] rd_node;
    logic [CNT_W-1:0]  cnt_rd;
    logic [CNT_W-1:0]  idx_next;
    logic              more_slots;
    logic              key_lt;
    state_t            end_state;

    // Counter read follows the incoming request while idle so the empty-node
    // decision can be made in the accept cycle.
    assign rd_node = (state_q == ST_IDLE) ? in_node : node_q;

    quickq_node_count #(
        .NODES(NODES),
        .SLOTS(SLOTS)
    ) u_count (
        .clk     (clk),
        .rst     (rst),
        .rd_node (rd_node),
        .rd_cnt  (cnt_rd),
        .inc     (state_q == ST_APPEND),
        .inc_node(node_q)
    );

    assign idx_next   = idx_q + CNT_W'(1);
    assign more_slots = idx_next < cnt_rd;
    assign key_lt     = temp_q < mem_rdata;
    assign end_state  = (cnt_rd == CNT_W'(SLOTS)) ? ST_SPILL : ST_APPEND;

    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        hold_d  = hold_q;
        node_d  = node_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    temp_d  = in_key;
                    node_d  = in_node;
                    idx_d   = '0;
                    state_d = (cnt_rd != '0) ? ST_READ : ST_APPEND;
                end
            end
            ST_READ:    state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (key_lt) begin
                    hold_d  = mem_rdata;
                    state_d = ST_SWAP;
                end else begin
                    idx_d   = idx_next;
                    state_d = more_slots ? ST_READ : end_state;
                end
            end
            ST_SWAP: begin
                temp_d  = hold_q;
                idx_d   = idx_next;
                state_d = more_slots ? ST_READ : end_state;
            end
            ST_APPEND:  state_d = ST_IDLE;
            ST_SPILL:   if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            temp_q  <= '0;
            hold_q  <= '0;
            node_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            hold_q  <= hold_d;
            node_q  <= node_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode the registered state only; nothing depends on inputs
    // except the compare outcome and the spill handshake.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_READ: begin
                mem_addr = ADDR_W'(slot_addr(32'(node_q), 32'(idx_q), 32'(SLOTS)));
            end
            ST_SWAP: begin
                mem_addr  = ADDR_W'(slot_addr(32'(node_q), 32'(idx_q), 32'(SLOTS)));
                mem_we    = 1'b1;
                mem_wdata = temp_q;
            end
            ST_APPEND: begin
                mem_addr  = ADDR_W'(slot_addr(32'(node_q), 32'(cnt_rd), 32'(SLOTS)));
                mem_we    = 1'b1;
                mem_wdata = temp_q;
            end
            default: ;
        endcase
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign result       = (state_q == ST_COMPARE) && key_lt;
    assign out_valid    = (state_q == ST_SPILL);
    assign out_key      = out_valid ? temp_q : '0;
    assign out_node     = out_valid ? node_q + NODE_W'(1) : '0;
    assign out_overflow = out_valid && (node_q == NODE_W'(NODES - 1));
    assign done         = (state_q == ST_APPEND) || (out_valid && out_ready);

endmodule

// File: tb/tb_quickq_node_insert.sv
// Bench for quickq_node_insert: BRAM model, sorted-node reference model and a
// scoreboard of expected completions (append or spill).
module tb_quickq_node_insert;

    localparam int KEY_W  = 16;
    localparam int SLOTS  = 4;
    localparam int NODES  = 16;
    localparam int NODE_W = 4;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [KEY_W-1:0]  in_key = '0;
    logic [NODE_W-1:0] in_node = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [KEY_W-1:0]  out_key;
    logic [NODE_W-1:0] out_node;
    logic              out_overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [KEY_W-1:0]  mem_wdata;
    logic [KEY_W-1:0]  mem_rdata = '0;
    logic              busy;
    logic              result;
    logic              done;

    quickq_node_insert #(.KEY_W(KEY_W), .SLOTS(SLOTS), .NODES(NODES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_node(in_node),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
        .out_node(out_node), .out_overflow(out_overflow),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .result(result), .done(done)
    );

    always #5 clk = ~clk;

    logic [KEY_W-1:0] mem [NODES*SLOTS];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit               spill;
        logic [KEY_W-1:0] key;
        logic [NODE_W-1:0] node;
        bit               ovf;
    } exp_t;
    exp_t exp_q[$];

    logic [KEY_W-1:0] mdl [NODES][SLOTS];
    int               mcnt [NODES];

    logic [ADDR_W-1:0] w_addr[$];
    logic [KEY_W-1:0]  w_data[$];
    int ones;
    int k_done;
    int k_out;

    // Reference: stable sorted insertion; a full node sheds its last element.
    function automatic void model_insert(input int n, input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] tmp [SLOTS+1];
        int c;
        int p;
        exp_t e;
        c = mcnt[n];
        p = c;
        for (int i = 0; i < c; i++)
            if (p == c && k < mdl[n][i]) p = i;
        for (int i = 0; i <= c; i++)
            tmp[i] = (i < p) ? mdl[n][i] : ((i == p) ? k : mdl[n][i-1]);
        e.node = NODE_W'((n + 1) % NODES);
        e.ovf  = (n == NODES - 1);
        if (c < SLOTS) begin
            for (int i = 0; i <= c; i++) mdl[n][i] = tmp[i];
            mcnt[n] = c + 1;
            e.spill = 1'b0;
            e.key   = '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) mdl[n][i] = tmp[i];
            e.spill = 1'b1;
            e.key   = tmp[SLOTS];
        end
        exp_q.push_back(e);
    endfunction

    task automatic do_insert(input int n, input logic [KEY_W-1:0] key, input int hold);
        int   waitc;
        exp_t e;
        bit   seen;
        bit   finished;
        logic [KEY_W-1:0]  sk;
        logic [NODE_W-1:0] sn;
        logic              so;
        w_addr.delete();
        w_data.delete();
        ones = 0; k_done = -1; k_out = -1;
        seen = 0; finished = 0;
        sk = '0; sn = '0; so = 1'b0;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check_eq("accept_wait", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1; in_key = key; in_node = NODE_W'(n);
        model_insert(n, key);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 100 && !finished; k++) begin
            if (mem_we) begin
                w_addr.push_back(mem_addr);
                w_data.push_back(mem_wdata);
            end
            if (result) ones++;
            if (done && !out_valid) begin
                if (exp_q.size() == 0) check_eq("unexpected_append", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("append_kind", 32'(0), 32'(e.spill));
                end
                k_done = k;
                finished = 1;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1; k_out = k;
                    sk = out_key; sn = out_node; so = out_overflow;
                    if (exp_q.size() == 0) check_eq("unexpected_spill", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check_eq("spill_kind", 32'(1), 32'(e.spill));
                        check_eq("out_key", 32'(out_key), 32'(e.key));
                        check_eq("out_node", 32'(out_node), 32'(e.node));
                        check_eq("out_overflow", 32'(out_overflow), 32'(e.ovf));
                    end
                end else begin
                    check_eq("hold_key", 32'(out_key), 32'(sk));
                    check_eq("hold_node", 32'(out_node), 32'(sn));
                    check_eq("hold_ovf", 32'(out_overflow), 32'(so));
                end
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                    #1;
                    check_eq("done_on_accept", 32'(done), 32'd1);
                    k_done = k;
                    finished = 1;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (!finished) check_eq("insert_timeout", 32'd0, 32'd1);
        check_eq("idle_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < mcnt[n]; i++)
            check_eq($sformatf("node%0d_slot%0d", n, i), 32'(mem[n*SLOTS+i]), 32'(mdl[n][i]));
        $display("insert node=%0d key=0x%0h writes=%0d swaps=%0d done_k=%0d spill_k=%0d",
                 n, key, w_addr.size(), ones, k_done, k_out);
    endtask

    task automatic check_writes(input string tag, input int idx,
                                input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] d);
        if (w_addr.size() > idx) begin
            check_eq({tag, "_addr"}, 32'(w_addr[idx]), 32'(a));
            check_eq({tag, "_data"}, 32'(w_data[idx]), 32'(d));
        end else begin
            check_eq({tag, "_present"}, 32'(w_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NODES*SLOTS; i++) mem[i] = '0;
        for (int i = 0; i < NODES; i++) mcnt[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_out_key", 32'(out_key), 32'd0);
        check_eq("rst_out_node", 32'(out_node), 32'd0);
        check_eq("rst_out_ovf", 32'(out_overflow), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        @(negedge clk);

        // Empty node: single append, done one cycle after accept.
        do_insert(3, 16'h0050, 0);
        check_eq("empty_writes", 32'(w_addr.size()), 32'd1);
        check_writes("empty_w0", 0, 6'd12, 16'h0050);
        check_eq("empty_done_k", 32'(k_done), 32'd1);

        // Two-key node with one swap then append.
        do_insert(0, 16'd10, 0);
        do_insert(0, 16'd30, 0);
        do_insert(0, 16'd20, 0);
        check_eq("mid_writes", 32'(w_addr.size()), 32'd2);
        check_writes("mid_w0", 0, 6'd1, 16'd20);
        check_writes("mid_w1", 1, 6'd2, 16'd30);
        check_eq("mid_swaps", 32'(ones), 32'd1);

        // Full node with swaps spills the largest key downstream.
        do_insert(0, 16'd40, 0);
        do_insert(0, 16'd25, 0);
        check_writes("full_w0", 0, 6'd2, 16'd25);
        check_writes("full_w1", 1, 6'd3, 16'd30);
        check_eq("full_swaps", 32'(ones), 32'd2);

        // Last node, no swaps: overflow spill, held off for 5 cycles.
        for (int i = 1; i <= SLOTS; i++) do_insert(15, 16'(i), 0);
        do_insert(15, 16'hFFFF, 5);
        check_eq("ovf_writes", 32'(w_addr.size()), 32'd0);
        check_eq("ovf_spill_k", 32'(k_out), 32'(1 + 2*SLOTS));

        // Equal key lands after the existing one without a swap.
        do_insert(5, 16'd20, 0);
        do_insert(5, 16'd20, 0);
        check_eq("eq_swaps", 32'(ones), 32'd0);
        check_eq("eq_writes", 32'(w_addr.size()), 32'd1);
        check_writes("eq_w0", 0, 6'd21, 16'd20);

        // Reset while the engine is in a swap.
        do_insert(7, 16'd10, 0);
        do_insert(7, 16'd20, 0);
        do_insert(7, 16'd30, 0);
        in_valid = 1'b1; in_key = 16'd5; in_node = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !mem_we; k++) @(negedge clk);
        check_eq("swap_reached", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_we", 32'(mem_we), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NODES; i++) mcnt[i] = 0;
        exp_q.delete();
        #1;
        check_eq("rst_rel_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("rst_rel_no_we", 32'(mem_we), 32'd0);
        end
        $display("reset during swap released");
        do_insert(7, 16'h0077, 0);
        check_eq("cleared7_done_k", 32'(k_done), 32'd1);
        check_writes("cleared7_w0", 0, 6'd28, 16'h0077);
        do_insert(0, 16'h0011, 0);
        check_eq("cleared0_done_k", 32'(k_done), 32'd1);
        check_writes("cleared0_w0", 0, 6'd0, 16'h0011);

        // Random mix over a few nodes, small key range for ties.
        for (int t = 0; t < 40; t++)
            do_insert(int'($urandom_range(8, 11)), 16'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)));

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
